// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage in-order pipe: forwarding, load-use and multicycle stalls, redirect flush.
// Latency: all control outputs are combinational from registered E/M/W state plus decode/redirect inputs.
// Backpressure: stall_f/stall_d hold the front end; bubble_e/bubble_m insert NOPs; nothing is dropped.
module pipe_hazard_ctrl #(
    parameter int REGW   = 5,
    parameter int MC_LAT = 4,
    parameter int CNTW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_d,
    input  logic [REGW-1:0] rs1_d,
    input  logic [REGW-1:0] rs2_d,
    input  logic            use_rs1_d,
    input  logic            use_rs2_d,
    input  logic [REGW-1:0] rd_d,
    input  logic            regwrite_d,
    input  logic            load_d,
    input  logic            mc_d,
    input  logic            redirect_e,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            bubble_e,
    output logic            bubble_m,
    output logic [1:0]      forward_a_e,
    output logic [1:0]      forward_b_e,
    output logic            valid_e,
    output logic            valid_m,
    output logic            valid_w,
    output logic            mc_busy,
    output logic [CNTW-1:0] stall_cnt
);
    localparam logic [3:0] MC_INIT = 4'(MC_LAT - 1);

    logic            r_e_vld, r_e_rw, r_e_ld;
    logic [REGW-1:0] r_e_rd, r_e_rs1, r_e_rs2;
    logic            r_m_vld, r_m_rw;
    logic [REGW-1:0] r_m_rd;
    logic            r_w_vld, r_w_rw;
    logic [REGW-1:0] r_w_rd;
    logic [3:0]      r_mc_cnt;
    logic [CNTW-1:0] r_stall_cnt;

    logic w_mc_busy;
    logic w_redir;
    logic w_load_use;

    // M beats W; register 0 never forwards.
    function automatic logic [1:0] f_fwd(
        input logic [REGW-1:0] rs,
        input logic            m_wr,
        input logic [REGW-1:0] m_rd,
        input logic            w_wr,
        input logic [REGW-1:0] w_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (m_wr && (m_rd == rs)) begin
                sel = 2'b10;
            end else if (w_wr && (w_rd == rs)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_mc_busy  = (r_mc_cnt != 4'd0);
        w_redir    = redirect_e & r_e_vld & ~w_mc_busy;
        w_load_use = r_e_vld & r_e_ld & r_e_rw & (r_e_rd != '0) & valid_d &
                     ((use_rs1_d & (rs1_d == r_e_rd)) | (use_rs2_d & (rs2_d == r_e_rd)));

        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        bubble_e = 1'b0;
        bubble_m = 1'b0;
        if (w_redir) begin
            flush_d  = 1'b1;
            bubble_e = 1'b1;
        end else if (w_mc_busy) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_m = 1'b1;
        end else if (w_load_use) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
        end

        forward_a_e = f_fwd(r_e_rs1, r_m_vld & r_m_rw, r_m_rd, r_w_vld & r_w_rw, r_w_rd);
        forward_b_e = f_fwd(r_e_rs2, r_m_vld & r_m_rw, r_m_rd, r_w_vld & r_w_rw, r_w_rd);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e_vld  <= 1'b0;
            r_e_rw   <= 1'b0;
            r_e_ld   <= 1'b0;
            r_e_rd   <= '0;
            r_e_rs1  <= '0;
            r_e_rs2  <= '0;
            r_m_vld  <= 1'b0;
            r_m_rw   <= 1'b0;
            r_m_rd   <= '0;
            r_w_vld  <= 1'b0;
            r_w_rw   <= 1'b0;
            r_w_rd   <= '0;
            r_mc_cnt <= 4'd0;
        end else begin
            r_w_vld <= r_m_vld;
            r_w_rw  <= r_m_rw;
            r_w_rd  <= r_m_rd;
            if (w_mc_busy) begin
                // E holds the multicycle op; M takes a bubble each busy cycle.
                r_mc_cnt <= r_mc_cnt - 4'd1;
                r_m_vld  <= 1'b0;
                r_m_rw   <= 1'b0;
                r_m_rd   <= '0;
            end else begin
                r_m_vld <= r_e_vld;
                r_m_rw  <= r_e_rw;
                r_m_rd  <= r_e_rd;
                if (valid_d && !bubble_e) begin
                    r_e_vld  <= 1'b1;
                    r_e_rw   <= regwrite_d;
                    r_e_ld   <= load_d;
                    r_e_rd   <= rd_d;
                    r_e_rs1  <= rs1_d;
                    r_e_rs2  <= rs2_d;
                    r_mc_cnt <= mc_d ? MC_INIT : 4'd0;
                end else begin
                    // Zeroed sources keep an empty E from selecting a forward.
                    r_e_vld  <= 1'b0;
                    r_e_rw   <= 1'b0;
                    r_e_ld   <= 1'b0;
                    r_e_rd   <= '0;
                    r_e_rs1  <= '0;
                    r_e_rs2  <= '0;
                    r_mc_cnt <= 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (stall_d && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNTW'(1);
        end
    end

    assign valid_e   = r_e_vld;
    assign valid_m   = r_m_vld;
    assign valid_w   = r_w_vld;
    assign mc_busy   = w_mc_busy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have these parameters, one per line: name, default, meaning.
- REGW, 5, register-index width; register 0 is hardwired zero.
- MC_LAT, 4, execute-stage occupancy in cycles of a multicycle op; legal range 1..15.
- CNTW, 32, width of the stall-cycle performance counter.

REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- valid_d, in, 1, decode holds a real instruction.
- rs1_d / rs2_d, in, REGW, decode source indices.
- use_rs1_d / use_rs2_d, in, 1, the corresponding source is read.
- rd_d, in, REGW, decode destination index.
- regwrite_d / load_d / mc_d, in, 1, decode writes rd / is a load / is multicycle.
- redirect_e, in, 1, branch taken, jal or jalr resolved in execute.
- stall_f / stall_d, out, 1, hold PC / hold the F->D register.
- flush_d, out, 1, clear the F->D register to a NOP.
- bubble_e, out, 1, load a NOP into the D->E register.
- bubble_m, out, 1, load a NOP into the E->M register.
- forward_a_e / forward_b_e, out, 2, operand select: 00 register file, 01 writeback, 10 memory.
- valid_e / valid_m / valid_w, out, 1, stage-valid flags.
- mc_busy, out, 1, a multicycle op is occupying execute.
- stall_cnt, out, CNTW, count of cycles with stall_d high.

REQ-003 SHALL use clk and rst exactly as named; reset is asynchronous active-low, one clock domain.

Function
REQ-004 SHALL keep a per-stage record {valid, rd, regwrite, load, rs1, rs2} for E, M and W, advanced each cycle unless the stage is held.
- Bubbles write valid=0; other fields are don't-care when valid=0.

REQ-005 SHALL compute forwarding combinationally from the registered E sources:
- select 10 if M.valid & M.regwrite & M.rd==rsX_E & rsX_E!=0;
- else 01 under the same test against W;
- else 00.
- M has priority over W.

REQ-006 SHALL detect load-use: E.valid & E.load & E.regwrite & E.rd!=0 & valid_d & ((use_rs1_d & rs1_d==E.rd) | (use_rs2_d & rs2_d==E.rd)).
- Response: stall_f=stall_d=bubble_e=1 for exactly one cycle.

REQ-007 SHALL start a multicycle counter when an op with mc_d=1 enters E: load MC_LAT-1.
- While the counter is nonzero: mc_busy=1, stall_f=stall_d=1, E is held, bubble_m=1.
- The counter decrements each cycle.
- The op advances to M on the cycle the counter reads 0.
- With MC_LAT=1 there is no stall.

REQ-008 SHALL honour redirect_e only when E.valid=1 and mc_busy=0.
- Response: flush_d=1 and bubble_e=1 the same cycle; stall_f=0 so the PC loads the target.
- The flushed decode instruction never reaches E.

REQ-009 SHALL give priority redirect > multicycle hold > load-use. A load-use condition coinciding with an honoured redirect produces no stall.

REQ-010 SHALL never detect a hazard against register 0, against invalid stages, or when valid_d=0.

REQ-011 SHALL increment stall_cnt on every cycle with stall_d=1, saturating at all-ones with no wrap.

REQ-012 SHALL have zero-cycle latency: all control outputs are combinational from current state plus the decode and redirect inputs.

REQ-013 SHALL, when a mc op in E finishes on the same cycle a load-use is pending in D, apply the load-use stall on the next cycle if it still holds.

Reset
REQ-014 SHALL on rst low:
- clear valid_e, valid_m and valid_w, the mc counter and stall_cnt immediately;
- drive forwards to 00 and all stall, flush and bubble outputs to 0.

REQ-015 SHALL, on reset assertion mid-multicycle or mid-stall, abandon the operation; the first cycle after release behaves as an empty pipeline.

Verification
REQ-016 add x5 then add x6,x5 back-to-back -> forward_a_e=10 in the cycle the second add is in E; with one NOP between them -> 01.
REQ-017 lw x5 then add x6,x5,x0 -> exactly one cycle of stall_f=stall_d=bubble_e=1, then forward_a_e=01; stall_cnt increments by 1.
REQ-018 MC_LAT=4, mc op into E -> mc_busy=1 and bubble_m=1 for 3 cycles, op reaches M on the 4th; stall_cnt +3.
REQ-019 redirect_e=1 while D holds a load-use consumer -> flush_d=1, bubble_e=1, stall_f=0, no stall cycle.
REQ-020 Writes to x0 in M and W with rs1_E=0 -> forward_a_e=00; rst pulsed low during mc_busy -> all valids 0 and mc_busy=0 asynchronously; stall_cnt preloaded near all-ones -> holds at all-ones.
